// File: rtl/integer_unit_serial.sv
// Serial warp-wide integer ALU: computes LanesPerCycle lanes per cycle into a
// result buffer, then presents the full warp result to the result collector.
package integer_unit_serial_pkg;
  typedef enum logic [4:0] {
    IU_TID, IU_WID, IU_BID, IU_TBID, IU_ADD, IU_ADDI, IU_SUB, IU_SUBI, IU_LDI,
    IU_OR, IU_AND, IU_XOR, IU_SHL, IU_SHLI, IU_SHR, IU_SRA, IU_MUL, IU_SLT
  } iu_subtype_e;
  // Bit n set when subtype value n is implemented.
  localparam logic [31:0] IU_VALID_SUBTYPES = 32'h0003_FFFF;
endpackage

module integer_unit_serial_lane
  import integer_unit_serial_pkg::*;
#(
  parameter int RegWidth  = 32,
  parameter int WarpWidth = 4
) (
  input  iu_subtype_e         op,
  input  logic [RegWidth-1:0] a,
  input  logic [RegWidth-1:0] b,
  input  logic [RegWidth-1:0] lane_idx,
  input  logic [RegWidth-1:0] wid,
  input  logic [RegWidth-1:0] bid,
  output logic [RegWidth-1:0] res
);
  localparam int SW = $clog2(RegWidth);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    res = '0;
    case (op)
      IU_TID:           res = lane_idx;
      IU_WID:           res = wid;
      IU_BID:           res = bid;
      IU_TBID:          res = bid * RegWidth'(WarpWidth) + lane_idx;
      IU_ADD, IU_ADDI:  res = a + b;
      IU_SUB, IU_SUBI:  res = a - b;
      IU_LDI, IU_OR:    res = a | b;
      IU_AND:           res = a & b;
      IU_XOR:           res = a ^ b;
      IU_SHL, IU_SHLI:  res = a << sh;
      IU_SHR:           res = a >> sh;
      IU_SRA:           res = $signed(a) >>> sh;
      IU_MUL:           res = a * b;
      IU_SLT:           res = {{(RegWidth-1){1'b0}}, $signed(a) < $signed(b)};
      default:          res = '0;
    endcase
  end
endmodule

module integer_unit_serial
  import integer_unit_serial_pkg::*;
#(
  parameter int NumTags       = 8,
  parameter int RegWidth      = 32,
  parameter int WarpWidth     = 4,
  parameter int NumWarps      = 8,
  parameter int RegIdxWidth   = 8,
  parameter int TblockIdxBits = 4,
  parameter int LanesPerCycle = 2,
  parameter int SkipInactive  = 1,
  localparam int TagWidth  = $clog2(NumTags),
  localparam int WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int NumGroups = WarpWidth / LanesPerCycle
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NumWarps-1:0][TblockIdxBits-1:0]     fe_to_iu_warp_tblock_idx_i,
  output logic                                       eu_to_opc_ready_o,
  input  logic                                       opc_to_eu_valid_i,
  input  logic [TagWidth+WidWidth-1:0]               opc_to_eu_tag_i,
  input  logic [WarpWidth-1:0]                       opc_to_eu_act_mask_i,
  input  iu_subtype_e                                opc_to_eu_inst_sub_i,
  input  logic [RegIdxWidth-1:0]                     opc_to_eu_dst_i,
  input  logic [1:0][WarpWidth-1:0][RegWidth-1:0]    opc_to_eu_operands_i,
  input  logic                                       rc_to_eu_ready_i,
  output logic                                       eu_to_rc_valid_o,
  output logic [WarpWidth-1:0]                       eu_to_rc_act_mask_o,
  output logic [TagWidth+WidWidth-1:0]               eu_to_rc_tag_o,
  output logic [RegIdxWidth-1:0]                     eu_to_rc_dst_o,
  output logic [WarpWidth-1:0][RegWidth-1:0]         eu_to_rc_data_o
);
  localparam int GW = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int IW = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;

  if (WarpWidth % LanesPerCycle != 0) begin : g_lanes_chk
    $error("LanesPerCycle must divide WarpWidth");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_e;

  state_e                               state_q, state_d;
  logic [GW-1:0]                        grp_q;
  logic [TagWidth+WidWidth-1:0]         tag_q;
  logic [RegIdxWidth-1:0]               dst_q;
  logic [WarpWidth-1:0]                 mask_q;
  iu_subtype_e                          op_q;
  logic [WarpWidth-1:0][RegWidth-1:0]   a_q, b_q, res_q;
  logic [TblockIdxBits-1:0]             bid_q;
  logic                                 accept;
  logic [GW:0]                          first, nxt;

  function automatic logic [NumGroups-1:0] grp_act(input logic [WarpWidth-1:0] m);
    for (int g = 0; g < NumGroups; g++)
      grp_act[g] = (SkipInactive == 0) || (|m[g*LanesPerCycle +: LanesPerCycle]);
  endfunction

  // {found, index} of the lowest group >= start that needs computing.
  function automatic logic [GW:0] find_grp(input logic [NumGroups-1:0] act, input int start);
    find_grp = '0;
    for (int g = NumGroups - 1; g >= 0; g--)
      if (g >= start && act[g]) find_grp = {1'b1, GW'(g)};
  endfunction

  assign accept = opc_to_eu_valid_i && eu_to_opc_ready_o;
  assign first  = find_grp(grp_act(opc_to_eu_act_mask_i), 0);
  assign nxt    = find_grp(grp_act(mask_q), int'(grp_q) + 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = first[GW] ? COMPUTE : OUTPUT;
      COMPUTE: if (!nxt[GW]) state_d = OUTPUT;
      OUTPUT:  if (rc_to_eu_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the whole output side quiet in the same cycle.
  always_comb begin
    eu_to_opc_ready_o   = !rst_i && (state_q == IDLE);
    eu_to_rc_valid_o    = !rst_i && (state_q == OUTPUT);
    eu_to_rc_act_mask_o = rst_i ? '0 : mask_q;
    eu_to_rc_tag_o      = rst_i ? '0 : tag_q;
    eu_to_rc_dst_o      = rst_i ? '0 : dst_q;
    eu_to_rc_data_o     = rst_i ? '0 : res_q;
  end

  logic [LanesPerCycle-1:0][IW-1:0]       gi;
  logic [LanesPerCycle-1:0][RegWidth-1:0] raw, lres;

  for (genvar l = 0; l < LanesPerCycle; l++) begin : g_lane
    assign gi[l] = IW'(int'(grp_q) * LanesPerCycle + l);
    integer_unit_serial_lane #(.RegWidth(RegWidth), .WarpWidth(WarpWidth)) u_lane (
      .op       (op_q),
      .a        (a_q[gi[l]]),
      .b        (b_q[gi[l]]),
      .lane_idx (RegWidth'(gi[l])),
      .wid      (RegWidth'(tag_q[WidWidth-1:0])),
      .bid      (RegWidth'(bid_q)),
      .res      (raw[l])
    );
    assign lres[l] = mask_q[gi[l]] ? raw[l] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grp_q  <= '0;
      tag_q  <= '0;
      dst_q  <= '0;
      mask_q <= '0;
      op_q   <= IU_TID;
      a_q    <= '0;
      b_q    <= '0;
      bid_q  <= '0;
      res_q  <= '0;
    end else if (accept) begin
      grp_q  <= first[GW-1:0];
      tag_q  <= opc_to_eu_tag_i;
      dst_q  <= opc_to_eu_dst_i;
      mask_q <= opc_to_eu_act_mask_i;
      op_q   <= opc_to_eu_inst_sub_i;
      a_q    <= opc_to_eu_operands_i[1];
      b_q    <= opc_to_eu_operands_i[0];
      bid_q  <= fe_to_iu_warp_tblock_idx_i[opc_to_eu_tag_i[WidWidth-1:0]];
      res_q  <= '0;
    end else if (state_q == COMPUTE) begin
      for (int l = 0; l < LanesPerCycle; l++) res_q[gi[l]] <= lres[l];
      grp_q <= nxt[GW-1:0];
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && accept && !IU_VALID_SUBTYPES[opc_to_eu_inst_sub_i])
      $error("integer_unit_serial: unknown subtype %0d", opc_to_eu_inst_sub_i);
  end
endmodule

// File: doc/integer_unit_serial.md
Name: integer_unit_serial

Overview:
- Area-reduced, parametrised successor of the integer execution unit: warp-wide integer ALU that processes LanesPerCycle threads per cycle over several cycles, time-multiplexing one slice of lane datapaths.
- Adds multiply, logical/arithmetic right shift and signed set-less-than to the existing subtypes; optionally skips lane groups with no active thread.
- Sits between operand collector and result collector, same handshake contract as the other execution units.

Parameters:
- NumTags, 8, inflight instructions per warp
- RegWidth, 32, register width in bits
- WarpWidth, 4, threads per warp
- NumWarps, 8, warps per compute unit
- RegIdxWidth, 8, register index width
- TblockIdxBits, 4, thread-block index width
- LanesPerCycle, 2, lanes computed per cycle; must divide WarpWidth (elaboration-time check)
- SkipInactive, 1, 1 = skip lane groups whose act_mask slice is all zero
- Derived (do not override): TagWidth=$clog2(NumTags), WidWidth=max(1,$clog2(NumWarps)), NumGroups=WarpWidth/LanesPerCycle, iid_t/reg_idx_t/act_mask_t/warp_data_t as elsewhere in the compute unit

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- fe_to_iu_warp_tblock_idx_i  in  NumWarps*TblockIdxBits  per-warp block index
- eu_to_opc_ready_o  out  1  ready to accept instruction
- opc_to_eu_valid_i  in  1  instruction valid
- opc_to_eu_tag_i  in  TagWidth+WidWidth  instruction id; low WidWidth bits = warp id
- opc_to_eu_act_mask_i  in  WarpWidth  active threads
- opc_to_eu_inst_sub_i  in  iu_subtype_e  operation
- opc_to_eu_dst_i  in  RegIdxWidth  destination register
- opc_to_eu_operands_i  in  2*WarpWidth*RegWidth  operands [1]=a, [0]=b
- rc_to_eu_ready_i  in  1  result collector ready
- eu_to_rc_valid_o  out  1  result valid
- eu_to_rc_act_mask_o / eu_to_rc_tag_o / eu_to_rc_dst_o  out  as input  echoed from accepted instruction
- eu_to_rc_data_o  out  WarpWidth*RegWidth  per-lane results

Behaviour:
- Reset (rst_i sampled high at posedge): state IDLE, group counter 0, result buffer 0; while rst_i high ready_o=0, valid_o=0, all data/tag/dst/mask outputs 0. Reset mid-COMPUTE or mid-OUTPUT discards the instruction.
- FSM IDLE: ready_o=1, valid_o=0. On valid&ready latch tag, dst, mask, subtype, operands, and block index of warp tag[WidWidth-1:0]; clear result buffer. Go COMPUTE at first group to compute; if none (SkipInactive=1 and mask all zero) go OUTPUT.
- COMPUTE: ready_o=0. Each cycle compute lanes [g*L, g*L+L-1] into result buffer, inactive lanes within the group written 0. Advance to next group to compute (all groups if SkipInactive=0, else groups with any active bit). After the last, go OUTPUT.
- OUTPUT: valid_o=1, payload stable until rc ready; on valid&ready go IDLE. No acceptance in same cycle (ready_o=1 first in next cycle).
- Latency: acceptance cycle = 0; k computed groups occupy cycles 1..k; valid_o high from cycle k+1. k=0 -> valid_o in cycle 1 with data all zero.
- Skipped groups and inactive lanes output 0.
- Ops per lane i (global lane index), a=operand[1], b=operand[0], results RegWidth wide, wrap modulo 2^RegWidth:
  - TID: i
  - WID: zero-extended warp id
  - BID: zero-extended latched block index
  - TBID: blockidx*WarpWidth+i
  - ADD/ADDI: a+b
  - SUB/SUBI: a-b
  - LDI/OR: a|b
  - AND: a&b
  - XOR: a^b
  - SHL/SHLI: a<<b[$clog2(RegWidth)-1:0]
  - SHR: logical right shift, same amount
  - SRA: arithmetic right shift, same amount
  - MUL: low RegWidth bits of a*b
  - SLT: signed a<b ? 1 : 0
- Shift amount masked to low $clog2(RegWidth) bits, e.g. 33 -> 1 for RegWidth=32.
- Unknown subtype: lanes 0; simulation-only $error at acceptance.
- iu_subtype_e gains IU_SHR, IU_SRA, IU_MUL, IU_SLT; IU_VALID_SUBTYPES extended accordingly.
- Backpressure: rc_ready low in OUTPUT holds state indefinitely; inputs ignored while not IDLE.

Test Plan:
- Defaults, ADD, mask 1111, a=lanes{10,20,30,40}, b=lanes{1,2,3,4} -> valid_o in cycle 3, data {11,22,33,44}, tag/dst echoed.
- MUL a=0xFFFF_FFFF, b=2, mask 0101, SkipInactive=1 -> 2 compute cycles, lanes {0xFFFF_FFFE,0,0xFFFF_FFFE,0}.
- SRA a=0x8000_0000, b=33 -> 0xC000_0000; SHR -> 0x4000_0000; SLT a=-1, b=0 -> 1.
- Mask 0000, SkipInactive=1 -> valid_o in cycle 1, data 0; same with SkipInactive=0 -> valid_o in cycle 3.
- TBID on warp 3 with blockidx[3]=5, WarpWidth=4 -> {20,21,22,23}; hold rc_ready low 10 cycles: outputs stable, ready_o=0.
- Assert rst_i in cycle 1 of COMPUTE -> next cycle valid_o=0, outputs 0; after release ready_o=1, a new ADD completes normally.
